// File: rtl/tv80_mem_responder_if.sv
// TV80 CPU-side bus seen by the memory responder: strobes and address in,
// wait/read-data/interrupt back toward the CPU.
interface tv80_mem_responder_if;
    logic [15:0] A;
    logic [7:0]  cpu_do;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        wait_n;
    logic [7:0]  dout;
    logic        dout_oe;
    logic        int_n;

    // The CPU holds A/strobes for the whole access and samples dout only while
    // dout_oe is high; wait_n low stretches the cycle, wait_n high lets it end.
    modport master (
        output A, cpu_do, m1_n, mreq_n, iorq_n, rd_n, wr_n,
        input  wait_n, dout, dout_oe, int_n
    );

    modport slave (
        input  A, cpu_do, m1_n, mreq_n, iorq_n, rd_n, wr_n,
        output wait_n, dout, dout_oe, int_n
    );
endinterface

// File: rtl/tv80_mem_responder.sv
// Memory-window slave for the tv80 bus: serves a 1-cycle-latency SRAM with
// programmable wait states and owns one maskable interrupt source.
module tv80_mem_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'hC000,
    parameter int          ADDR_W      = 13,
    parameter int          WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    tv80_mem_responder_if.slave bus,
    input  logic              irq_req,
    input  logic [7:0]        int_vector,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       is_read, is_read_nxt;
    logic       rd_issued_q;
    logic [7:0] rdata_q;
    logic       pending;

    logic       in_window;
    logic       strobe;
    logic       sel;
    logic       inta;

    logic       wait_n_c;
    logic [7:0] dout_c;
    logic       dout_oe_c;
    logic       mem_rd_c;
    logic       mem_wr_c;
    logic [7:0] mem_wdata_c;

    assign in_window = (bus.A[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);
    assign strobe    = ~bus.mreq_n & (~bus.rd_n | ~bus.wr_n);
    assign sel       = in_window & strobe;
    assign inta      = ~bus.m1_n & ~bus.iorq_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            is_read     <= 1'b0;
            rd_issued_q <= 1'b0;
            rdata_q     <= 8'd0;
            pending     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            is_read     <= is_read_nxt;
            rd_issued_q <= mem_rd_c;
            // SRAM data is only valid the cycle after the read enable
            if (rd_issued_q) begin
                rdata_q <= mem_rdata;
            end
            // a request arriving with the acknowledge wins over the clear
            pending <= irq_req | (pending & ~inta);
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        is_read_nxt = is_read;
        wait_n_c    = 1'b1;
        dout_c      = 8'd0;
        dout_oe_c   = 1'b0;
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        mem_wdata_c = 8'd0;

        case (state)
            IDLE: begin
                if (sel) begin
                    wait_n_c = 1'b0;
                    cnt_nxt  = CNT_LOAD;
                    if (!bus.rd_n) begin
                        mem_rd_c    = 1'b1;
                        is_read_nxt = 1'b1;
                    end else begin
                        mem_wr_c    = 1'b1;
                        mem_wdata_c = bus.cpu_do;
                        is_read_nxt = 1'b0;
                    end
                    state_nxt = (WAIT_STATES > 1) ? WAIT : READY;
                end
            end
            WAIT: begin
                wait_n_c = 1'b0;
                if (!strobe) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = READY;
                    end
                end
            end
            READY: begin
                // with a single wait state the SRAM data is still only on mem_rdata
                if (is_read) begin
                    dout_c    = rd_issued_q ? mem_rdata : rdata_q;
                    dout_oe_c = 1'b1;
                end
                state_nxt = DONE;
            end
            DONE: begin
                if (is_read && strobe) begin
                    dout_c    = rdata_q;
                    dout_oe_c = 1'b1;
                end
                if (!strobe) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (inta) begin
            wait_n_c    = 1'b1;
            dout_c      = int_vector;
            dout_oe_c   = 1'b1;
            mem_rd_c    = 1'b0;
            mem_wr_c    = 1'b0;
            mem_wdata_c = 8'd0;
        end

        // outputs drop to their idle values within the reset cycle itself
        if (!reset_n) begin
            state_nxt   = IDLE;
            cnt_nxt     = 4'd0;
            is_read_nxt = 1'b0;
            wait_n_c    = 1'b1;
            dout_c      = 8'd0;
            dout_oe_c   = 1'b0;
            mem_rd_c    = 1'b0;
            mem_wr_c    = 1'b0;
            mem_wdata_c = 8'd0;
        end
    end

    assign bus.wait_n  = wait_n_c;
    assign bus.dout    = dout_c;
    assign bus.dout_oe = dout_oe_c;
    assign bus.int_n   = reset_n ? ~pending : 1'b1;

    assign mem_addr  = bus.A[ADDR_W-1:0];
    assign mem_rd    = mem_rd_c;
    assign mem_wr    = mem_wr_c;
    assign mem_wdata = mem_wdata_c;
    assign busy      = reset_n & (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_tv80_mem_responder.sv
// Bench for tv80_mem_responder: a 2-wait-state and a 1-wait-state instance
// driven by a CPU-like bus driver, checked against a memory/interrupt model.
module tb_tv80_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic load;
    logic [7:0] seed;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] a_v   [2];
    logic [7:0]  do_v  [2];
    logic        m1_v  [2];
    logic        mreq_v[2];
    logic        iorq_v[2];
    logic        rd_v  [2];
    logic        wr_v  [2];
    logic        irq_v [2];
    logic [7:0]  vec_v [2];

    wire         wait_n_o   [2];
    wire [7:0]   dout_o     [2];
    wire         dout_oe_o  [2];
    wire         int_n_o    [2];
    wire [12:0]  mem_addr_o [2];
    wire         mem_rd_o   [2];
    wire         mem_wr_o   [2];
    wire [7:0]   mem_wdata_o[2];
    wire         busy_o     [2];
    wire [1:0]   state_o    [2];
    logic [7:0]  sram_q     [2];

    logic [7:0]  sram    [2][8192];
    logic [7:0]  exp_mem [2][8192];
    int          rd_cnt  [2] = '{0, 0};
    int          wr_cnt  [2] = '{0, 0};

    tv80_mem_responder_if bus [2] ();

    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign bus[k].A      = a_v[k];
        assign bus[k].cpu_do = do_v[k];
        assign bus[k].m1_n   = m1_v[k];
        assign bus[k].mreq_n = mreq_v[k];
        assign bus[k].iorq_n = iorq_v[k];
        assign bus[k].rd_n   = rd_v[k];
        assign bus[k].wr_n   = wr_v[k];
        assign wait_n_o[k]   = bus[k].wait_n;
        assign dout_o[k]     = bus[k].dout;
        assign dout_oe_o[k]  = bus[k].dout_oe;
        assign int_n_o[k]    = bus[k].int_n;

        tv80_mem_responder #(
            .BASE_ADDR  (16'hC000),
            .ADDR_W     (13),
            .WAIT_STATES(k == 0 ? 2 : 1)
        ) dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .bus       (bus[k]),
            .irq_req   (irq_v[k]),
            .int_vector(vec_v[k]),
            .mem_addr  (mem_addr_o[k]),
            .mem_rd    (mem_rd_o[k]),
            .mem_wr    (mem_wr_o[k]),
            .mem_wdata (mem_wdata_o[k]),
            .mem_rdata (sram_q[k]),
            .busy      (busy_o[k]),
            .state_dbg (state_o[k])
        );
    end

    function automatic logic [7:0] init_byte(input int k, input int i);
        if (k == 0 && i == 16'h0010) return 8'h5A;
        return 8'(i * 29 + k * 91) ^ seed;
    endfunction

    // Synchronous SRAM: data appears the cycle after mem_rd, garbage otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (load) begin
                for (int i = 0; i < 8192; i++) sram[k][i] = init_byte(k, i);
            end else if (mem_wr_o[k]) begin
                sram[k][mem_addr_o[k]] = mem_wdata_o[k];
            end
            sram_q[k] <= mem_rd_o[k] ? sram[k][mem_addr_o[k]] : 8'hEE;
            if (mem_rd_o[k]) rd_cnt[k] = rd_cnt[k] + 1;
            if (mem_wr_o[k]) wr_cnt[k] = wr_cnt[k] + 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic bit in_win(input logic [15:0] addr);
        return addr[15:13] == 3'b110;
    endfunction

    task automatic bus_idle(input int k);
        a_v[k] = 16'h0000; do_v[k] = 8'h00;
        m1_v[k] = 1'b1; mreq_v[k] = 1'b1; iorq_v[k] = 1'b1;
        rd_v[k] = 1'b1; wr_v[k] = 1'b1;
    endtask

    // One CPU memory access; holds the strobe until wait_n rises, then one
    // extra cycle, then releases.
    task automatic mem_access(input int k, input bit is_wr, input logic [15:0] addr,
                              input logic [7:0] wdata);
        int low;
        int rd0;
        int wr0;
        bit win;
        logic [7:0] expd;
        win  = in_win(addr);
        rd0  = rd_cnt[k];
        wr0  = wr_cnt[k];
        expd = exp_mem[k][addr[12:0]];
        @(posedge clk); #1;
        a_v[k] = addr; mreq_v[k] = 1'b0;
        if (is_wr) begin do_v[k] = wdata; wr_v[k] = 1'b0; end
        else rd_v[k] = 1'b0;
        @(negedge clk);
        if (win) begin
            check(is_wr ? "wr_c0_strobe" : "rd_c0_strobe",
                  16'(is_wr ? mem_wr_o[k] : mem_rd_o[k]), 16'd1);
            check("c0_addr", 16'(mem_addr_o[k]), 16'(addr[12:0]));
            if (is_wr) check("wr_c0_wdata", 16'(mem_wdata_o[k]), 16'(wdata));
            low = 0;
            while (wait_n_o[k] === 1'b0 && low < 20) begin
                low++;
                @(negedge clk);
            end
            check("wait_len", 16'(low), 16'(ws_of(k)));
            if (is_wr) begin
                check("wr_ready_oe", 16'(dout_oe_o[k]), 16'd0);
                exp_mem[k][addr[12:0]] = wdata;
            end else begin
                check("rd_ready_data", {7'd0, dout_oe_o[k], dout_o[k]}, {8'h01, expd});
            end
            @(negedge clk);
            check("done_wait_busy", {14'd0, wait_n_o[k], busy_o[k]}, 16'h0003);
            if (!is_wr) check("rd_done_data", {7'd0, dout_oe_o[k], dout_o[k]}, {8'h01, expd});
        end else begin
            repeat (2) begin
                check("nosel_wait_oe", {14'd0, wait_n_o[k], dout_oe_o[k]}, 16'h0002);
                @(negedge clk);
            end
        end
        @(posedge clk); #1;
        mreq_v[k] = 1'b1; rd_v[k] = 1'b1; wr_v[k] = 1'b1;
        @(negedge clk);
        check("rd_pulses", 16'(rd_cnt[k] - rd0), 16'((win && !is_wr) ? 1 : 0));
        check("wr_pulses", 16'(wr_cnt[k] - wr0), 16'((win && is_wr) ? 1 : 0));
    endtask

    task automatic irq_pulse(input int k);
        @(posedge clk); #1; irq_v[k] = 1'b1;
        @(negedge clk);
        check("irq_int_n_same_cycle", 16'(int_n_o[k]), 16'd1);
        @(posedge clk); #1; irq_v[k] = 1'b0;
        @(negedge clk);
        check("irq_int_n_low", 16'(int_n_o[k]), 16'd0);
    endtask

    initial begin
        logic [15:0] addr;
        logic [7:0]  vec;
        int rd0;
        int wr0;

        seed = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            bus_idle(k);
            irq_v[k] = 1'b0; vec_v[k] = 8'h00;
            for (int i = 0; i < 8192; i++) exp_mem[k][i] = init_byte(k, i);
        end
        reset_n = 1'b0;
        load    = 1'b1;
        repeat (3) @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_wait_int", {14'd0, wait_n_o[k], int_n_o[k]}, 16'h0003);
            check("rst_dout", {7'd0, dout_oe_o[k], dout_o[k]}, 16'h0000);
            check("rst_mem", {5'd0, mem_rd_o[k], mem_wr_o[k], busy_o[k], mem_wdata_o[k]}, 16'h0000);
            check("rst_state", 16'(state_o[k]), 16'd0);
        end
        @(posedge clk); #1 reset_n = 1'b1;

        // Directed accesses on the 2-wait-state instance
        mem_access(0, 1'b0, 16'hC010, 8'h00);
        mem_access(0, 1'b1, 16'hDFFF, 8'hA5);
        mem_access(0, 1'b0, 16'hDFFF, 8'h00);
        mem_access(0, 1'b0, 16'hE000, 8'h00);
        mem_access(0, 1'b1, 16'hBFFF, 8'h3C);

        // IO read of port 0x10 must be ignored
        rd0 = rd_cnt[0]; wr0 = wr_cnt[0];
        @(posedge clk); #1;
        a_v[0] = 16'h0010; iorq_v[0] = 1'b0; rd_v[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("io_wait_oe", {14'd0, wait_n_o[0], dout_oe_o[0]}, 16'h0002);
        end
        @(posedge clk); #1 bus_idle(0);
        @(negedge clk);
        check("io_no_memop", 16'(rd_cnt[0] - rd0 + wr_cnt[0] - wr0), 16'd0);

        // Interrupt: request, acknowledge over two INTA cycles
        vec_v[0] = 8'h40;
        @(negedge clk);
        check("int_n_idle", 16'(int_n_o[0]), 16'd1);
        irq_pulse(0);
        @(posedge clk); #1 m1_v[0] = 1'b0; iorq_v[0] = 1'b0;
        @(negedge clk);
        check("inta_vec", {7'd0, dout_oe_o[0], dout_o[0]}, 16'h0140);
        check("inta_wait_int", {14'd0, wait_n_o[0], int_n_o[0]}, 16'h0002);
        @(posedge clk); #1;
        @(negedge clk);
        check("inta_cleared", {7'd0, int_n_o[0], dout_o[0]}, 16'h0140);
        @(posedge clk); #1 bus_idle(0);
        @(negedge clk);
        check("inta_release", {14'd0, dout_oe_o[0], int_n_o[0]}, 16'h0001);
        check("inta_no_memop", 16'(rd_cnt[0] - rd0 + wr_cnt[0] - wr0), 16'd0);

        // Request coincident with the clearing INTA keeps the interrupt pending
        irq_pulse(0);
        vec = 8'($urandom);
        @(posedge clk); #1 m1_v[0] = 1'b0; iorq_v[0] = 1'b0; irq_v[0] = 1'b1; vec_v[0] = vec;
        @(negedge clk);
        check("inta2_vec", 16'(dout_o[0]), 16'(vec));
        @(posedge clk); #1 bus_idle(0); irq_v[0] = 1'b0;
        @(negedge clk);
        check("irq_set_dominates", 16'(int_n_o[0]), 16'd0);
        @(posedge clk); #1 m1_v[0] = 1'b0; iorq_v[0] = 1'b0;
        @(posedge clk); #1 bus_idle(0);
        @(negedge clk);
        check("inta3_cleared", 16'(int_n_o[0]), 16'd1);

        // INTA with nothing pending still returns the vector
        vec = 8'($urandom);
        @(posedge clk); #1 m1_v[0] = 1'b0; iorq_v[0] = 1'b0; vec_v[0] = vec;
        @(negedge clk);
        check("inta_nopend", {7'd0, dout_oe_o[0], dout_o[0]}, {8'h01, vec});
        @(posedge clk); #1 bus_idle(0);

        // Abort: strobe released during WAIT
        rd0 = rd_cnt[0];
        @(posedge clk); #1 a_v[0] = 16'hC123; mreq_v[0] = 1'b0; rd_v[0] = 1'b0;
        @(posedge clk); #1 bus_idle(0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_idle", {13'd0, wait_n_o[0], busy_o[0], dout_oe_o[0]}, 16'h0004);
        check("abort_rd_once", 16'(rd_cnt[0] - rd0), 16'd1);

        // Reset during WAIT of a read, with an interrupt pending
        irq_pulse(0);
        @(posedge clk); #1 a_v[0] = 16'hC010; mreq_v[0] = 1'b0; rd_v[0] = 1'b0;
        @(negedge clk);
        check("rstmid_c0_wait", 16'(wait_n_o[0]), 16'd0);
        @(posedge clk); #1 reset_n = 1'b0;
        @(negedge clk);
        check("rstmid_in_reset", {12'd0, wait_n_o[0], dout_oe_o[0], busy_o[0], int_n_o[0]}, 16'h0009);
        @(posedge clk); #1 reset_n = 1'b1; bus_idle(0);
        @(negedge clk);
        check("rstmid_after", {12'd0, wait_n_o[0], dout_oe_o[0], busy_o[0], int_n_o[0]}, 16'h0009);
        mem_access(0, 1'b0, 16'hC010, 8'h00);

        // Single-wait-state instance: back-to-back reads
        mem_access(1, 1'b0, 16'hC000, 8'h00);
        mem_access(1, 1'b0, 16'hC001, 8'h00);
        mem_access(1, 1'b1, 16'hC001, 8'h77);
        mem_access(1, 1'b0, 16'hC001, 8'h00);

        // Random traffic on both instances
        for (int n = 0; n < 60; n++) begin
            int k;
            k = int'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       addr = 16'($urandom_range(16'h0000, 16'hBFFF));
                1:       addr = 16'($urandom_range(16'hE000, 16'hFFFF));
                2, 3, 4: addr = 16'hC000 | 16'($urandom_range(0, 8191));
                default: addr = 16'hC000 | 16'($urandom_range(0, 15));
            endcase
            mem_access(k, 1'($urandom_range(0, 1)), addr, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tv80_mem_responder.md
Name: tv80_mem_responder

Overview:
- Bus-slave counterpart to the tv80 CPU wrapper. It watches the CPU strobes (mreq_n/iorq_n/rd_n/wr_n/m1_n) and serves memory reads and writes in a decoded window from a synchronous 1-cycle-latency SRAM.
- It inserts a programmable number of wait states via wait_n.
- It also owns one maskable interrupt source: it drives int_n and supplies the vector byte during the interrupt-acknowledge cycle.

Parameters:
- BASE_ADDR, 16'hC000: window base. Only bits [15:ADDR_W] are compared.
- ADDR_W, 13: window/SRAM address width. Window size is 2^ADDR_W bytes.
- WAIT_STATES, 2: wait cycles inserted per access. Legal range 1..15. Minimum 1 covers SRAM read latency.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- A  in  16  CPU address
- cpu_do  in  8  CPU write data
- m1_n  in  1  CPU opcode-fetch / INTA qualifier
- mreq_n  in  1  CPU memory request
- iorq_n  in  1  CPU IO request
- rd_n  in  1  CPU read strobe
- wr_n  in  1  CPU write strobe
- wait_n  out  1  wait request to CPU, active-low
- dout  out  8  read/vector data toward CPU di
- dout_oe  out  1  dout valid; the system mux selects dout when high
- int_n  out  1  interrupt request to CPU, active-low
- irq_req  in  1  one-cycle interrupt request pulse from a peripheral
- int_vector  in  8  byte returned during INTA
- mem_addr  out  ADDR_W  SRAM address; combinational A[ADDR_W-1:0]
- mem_rd  out  1  SRAM read enable, one cycle
- mem_wr  out  1  SRAM write enable, one cycle
- mem_wdata  out  8  SRAM write data
- mem_rdata  in  8  SRAM read data, valid the cycle after mem_rd
- busy  out  1  high while state is not IDLE

Behaviour:
- Reset values: reset_n is synchronous, active-low; clock is clk. All outputs take these values during and after reset:
  - wait_n=1, int_n=1
  - dout=0, dout_oe=0
  - mem_rd=0, mem_wr=0, mem_wdata=0
  - busy=0, state=IDLE, cnt=0, irq pending=0
- sel = (A[15:ADDR_W]==BASE_ADDR[15:ADDR_W]) & ~mreq_n & (~rd_n | ~wr_n).
- States: IDLE, WAIT, READY, DONE. cnt is 4 bits.
- IDLE:
  - sel high in cycle c0: wait_n=0 combinationally.
  - Read: mem_rd=1 for c0 only. Write: mem_wr=1 for c0 only, with mem_wdata=cpu_do.
  - Latch direction; cnt<=WAIT_STATES-1.
  - Next state: WAIT if WAIT_STATES>1, else READY.
- WAIT:
  - wait_n=0.
  - Read: capture mem_rdata into rdata_q in c1.
  - cnt decrements each cycle; cnt==1 -> READY.
- READY:
  - wait_n=1.
  - Read: dout=rdata_q, dout_oe=1.
  - Write: dout_oe=0.
  - Next state: DONE.
- DONE:
  - wait_n=1.
  - dout_oe stays high for reads until the strobe releases (rd_n&wr_n high or mreq_n high), then IDLE.
  - A new access is recognised only from IDLE, so one access produces exactly one mem op.
- Overall timing: wait_n is low for exactly WAIT_STATES consecutive cycles starting at c0. Read data is valid from cycle c(WAIT_STATES) onward.
- Abort: strobe released while in WAIT -> IDLE next cycle, wait_n=1, no further mem op, dout_oe=0.
- Non-selected addresses and IO cycles (iorq_n low, m1_n high): no response, wait_n=1, dout_oe=0.
- Interrupts:
  - irq_req sets pending; int_n = ~pending (registered).
  - INTA = ~m1_n & ~iorq_n. While INTA is high: dout=int_vector, dout_oe=1, wait_n=1, no mem op. Pending clears on the first INTA cycle.
  - irq_req in the same cycle as the clearing INTA: set dominates, pending stays 1.
  - INTA with nothing pending still returns int_vector.
- Reset mid-operation: state returns to IDLE and all outputs take their reset values in the reset cycle, including wait_n=1. Pending is lost.

Test Plan:
- Read, WAIT_STATES=2, SRAM[0x0010]=0x5A, CPU reads 0xC010 -> mem_rd pulses one cycle with mem_addr=0x0010; wait_n low 2 cycles; dout=0x5A, dout_oe=1 in c2.
- Write 0xA5 to 0xDFFF -> mem_wr one cycle, mem_addr=0x1FFF, mem_wdata=0xA5, wait_n low 2 cycles; a following read of 0xDFFF returns 0xA5.
- Out-of-window read 0xE000 and IO read at port 0x10 -> wait_n stays 1, dout_oe=0, no mem_rd/mem_wr.
- irq_req pulse, int_vector=0x40 -> int_n low next cycle; INTA cycle gives dout=0x40, dout_oe=1; int_n high the cycle after INTA. Repeat with irq_req coincident with INTA -> int_n stays low.
- WAIT_STATES=1 build -> single wait cycle, data valid in c1; back-to-back reads of 0xC000 and 0xC001 each produce exactly one mem_rd.
- reset_n low in the WAIT state of a read -> next cycle wait_n=1, dout_oe=0, busy=0, int_n=1; the next read completes normally.
